// File: rtl/ti_sbox_delta_stage.sv
// 5-share TI stage computing shares of the GF(2^4) norm mu*A^2 ^ A*B ^ B^2 ahead of the shared inverter.
// The output register doubles as the glitch barrier between the nonlinear layers.
module ti_sbox_delta_stage #(
    parameter logic [3:0] MU = 4'h8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data_1,
    input  logic [7:0]  in_data_2,
    input  logic [7:0]  in_data_3,
    input  logic [7:0]  in_data_4,
    input  logic [7:0]  in_data_5,
    input  logic [19:0] rnd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_delta_1,
    output logic [3:0]  out_delta_2,
    output logic [3:0]  out_delta_3,
    output logic [3:0]  out_delta_4,
    output logic [3:0]  out_delta_5,
    output logic [3:0]  out_hi_1,
    output logic [3:0]  out_hi_2,
    output logic [3:0]  out_hi_3,
    output logic [3:0]  out_hi_4,
    output logic [3:0]  out_hi_5,
    output logic [3:0]  out_lo_1,
    output logic [3:0]  out_lo_2,
    output logic [3:0]  out_lo_3,
    output logic [3:0]  out_lo_4,
    output logic [3:0]  out_lo_5
);
    localparam int NUM_SHARES = 5;

    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        return {a[1] & b[1] ^ a[1] & b[0] ^ a[0] & b[1], a[1] & b[1] ^ a[0] & b[0]};
    endfunction

    function automatic logic [1:0] gf4_mul_w(input logic [1:0] a);
        return {a[1] ^ a[0], a[1]};
    endfunction

    function automatic logic [1:0] gf4_sq(input logic [1:0] a);
        return {a[1], a[1] ^ a[0]};
    endfunction

    function automatic logic [3:0] gf16_mul(input logic [3:0] x, input logic [3:0] y);
        logic [1:0] hh;
        hh = gf4_mul(x[3:2], y[3:2]);
        return {hh ^ gf4_mul(x[3:2], y[1:0]) ^ gf4_mul(x[1:0], y[3:2]),
                gf4_mul_w(hh) ^ gf4_mul(x[1:0], y[1:0])};
    endfunction

    function automatic logic [3:0] gf16_sq(input logic [3:0] x);
        logic [1:0] hs;
        hs = gf4_sq(x[3:2]);
        return {hs, gf4_mul_w(hs) ^ gf4_sq(x[1:0])};
    endfunction

    // Lowest share index not touched by either operand; keeps cross terms non-complete.
    function automatic int other_share(input int j, input int k);
        int sel;
        sel = 0;
        for (int m = NUM_SHARES - 1; m >= 0; m--)
            if (m != j && m != k) sel = m;
        return sel;
    endfunction

    logic [NUM_SHARES-1:0][7:0] din;
    logic [NUM_SHARES-1:0][3:0] r_nib;
    logic [NUM_SHARES-1:0][3:0] d_pre;
    logic [NUM_SHARES-1:0][3:0] d_ref;
    logic [NUM_SHARES-1:0][3:0] delta_q, hi_q, lo_q;
    logic                       valid_q;
    logic                       xfer;

    assign din   = {in_data_5, in_data_4, in_data_3, in_data_2, in_data_1};
    assign r_nib = rnd;

    always_comb begin
        d_pre = '0;
        for (int j = 0; j < NUM_SHARES; j++) begin
            d_pre[(j + 1) % NUM_SHARES] ^= gf16_mul(MU, gf16_sq(din[j][7:4])) ^ gf16_sq(din[j][3:0]);
            for (int k = 0; k < NUM_SHARES; k++) begin
                if (j == k)
                    d_pre[(j + 1) % NUM_SHARES] ^= gf16_mul(din[j][7:4], din[k][3:0]);
                else
                    d_pre[other_share(j, k)] ^= gf16_mul(din[j][7:4], din[k][3:0]);
            end
        end
    end

    // Each r_n lands in shares n and n+1 (cyclically), so the refresh sums to zero.
    always_comb begin
        d_ref = '0;
        for (int n = 0; n < NUM_SHARES; n++)
            d_ref[n] = d_pre[n] ^ r_nib[n] ^ r_nib[(n + NUM_SHARES - 1) % NUM_SHARES];
    end

    assign in_ready = !valid_q || out_ready;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            delta_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (xfer) begin
            valid_q <= 1'b1;
            delta_q <= d_ref;
            for (int n = 0; n < NUM_SHARES; n++) begin
                hi_q[n] <= din[n][7:4];
                lo_q[n] <= din[n][3:0];
            end
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign {out_delta_5, out_delta_4, out_delta_3, out_delta_2, out_delta_1} = delta_q;
    assign {out_hi_5, out_hi_4, out_hi_3, out_hi_2, out_hi_1} = hi_q;
    assign {out_lo_5, out_lo_4, out_lo_3, out_lo_2, out_lo_1} = lo_q;
endmodule

// File: tb/tb_ti_sbox_delta_stage.sv
// Bench for ti_sbox_delta_stage: table vectors, non-completeness sweeps, handshake corners and a
// randomized scoreboard against a log-table GF model.
module tb_ti_sbox_delta_stage;
    localparam logic [3:0] MU = 4'h8;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, out_valid, out_ready;
    logic [4:0][7:0]  td;
    logic [19:0]      rnd;
    logic [4:0][3:0]  od, oh, ol;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    ti_sbox_delta_stage #(.MU(MU)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data_1(td[0]), .in_data_2(td[1]), .in_data_3(td[2]), .in_data_4(td[3]), .in_data_5(td[4]),
        .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready),
        .out_delta_1(od[0]), .out_delta_2(od[1]), .out_delta_3(od[2]), .out_delta_4(od[3]), .out_delta_5(od[4]),
        .out_hi_1(oh[0]), .out_hi_2(oh[1]), .out_hi_3(oh[2]), .out_hi_4(oh[3]), .out_hi_5(oh[4]),
        .out_lo_1(ol[0]), .out_lo_2(ol[1]), .out_lo_3(ol[2]), .out_lo_4(ol[3]), .out_lo_5(ol[4])
    );

    // GF(4) through discrete logs: w generates the multiplicative group {1, w, w^2 = w+1}.
    function automatic int m_log(input logic [1:0] a);
        case (a)
            2'd1:    return 0;
            2'd2:    return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [1:0] m_exp(input int e);
        case (e % 3)
            0:       return 2'd1;
            1:       return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] m4(input logic [1:0] a, input logic [1:0] b);
        if (a == 0 || b == 0) return 2'd0;
        return m_exp(m_log(a) + m_log(b));
    endfunction

    // Polynomial product in Y, then reduce Y^2 -> Y + w.
    function automatic logic [3:0] m16(input logic [3:0] x, input logic [3:0] y);
        logic [1:0] c2, c1, c0;
        c2 = m4(x[3:2], y[3:2]);
        c1 = m4(x[3:2], y[1:0]) ^ m4(x[1:0], y[3:2]);
        c0 = m4(x[1:0], y[1:0]);
        return {c1 ^ c2, c0 ^ m4(c2, 2'd2)};
    endfunction

    function automatic logic [3:0] m_delta(input logic [7:0] v);
        return m16(MU, m16(v[7:4], v[7:4])) ^ m16(v[7:4], v[3:0]) ^ m16(v[3:0], v[3:0]);
    endfunction

    function automatic logic [19:0] m_shares(input logic [4:0][7:0] d, input logic [19:0] r);
        logic [4:0][3:0] acc;
        logic [4:0][3:0] rr;
        int m;
        acc = '0;
        rr  = r;
        for (int j = 0; j < 5; j++) begin
            acc[(j + 1) % 5] ^= m16(MU, m16(d[j][7:4], d[j][7:4])) ^ m16(d[j][3:0], d[j][3:0]);
            for (int k = 0; k < 5; k++) begin
                if (j == k) m = (j + 1) % 5;
                else begin
                    m = 0;
                    while (m == j || m == k) m++;
                end
                acc[m] ^= m16(d[j][7:4], d[k][3:0]);
            end
        end
        for (int n = 0; n < 5; n++) acc[n] ^= rr[n] ^ rr[(n + 4) % 5];
        return acc;
    endfunction

    function automatic logic [3:0] xor_sh(input logic [4:0][3:0] s);
        return s[0] ^ s[1] ^ s[2] ^ s[3] ^ s[4];
    endfunction

    function automatic logic [59:0] m_out(input logic [4:0][7:0] d, input logic [19:0] r);
        logic [4:0][3:0] h, l;
        for (int n = 0; n < 5; n++) begin
            h[n] = d[n][7:4];
            l[n] = d[n][3:0];
        end
        return {m_shares(d, r), h, l};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_shares(input logic [7:0] v);
        logic [7:0] acc;
        acc = v;
        for (int n = 1; n < 5; n++) begin
            td[n] = 8'($urandom);
            acc ^= td[n];
        end
        td[0] = acc;
    endtask

    typedef struct {
        logic [7:0] val;
        logic [3:0] exp_delta;
    } vec_t;

    vec_t             vecs[5];
    logic [59:0]      exp_q[$];
    logic [59:0]      first_res, second_res, third_res;
    logic [3:0]       ref_nib;
    logic             exp_rdy;

    initial begin
        vecs[0] = '{8'h00, 4'h0};
        vecs[1] = '{8'h01, 4'h1};
        vecs[2] = '{8'h10, 4'h8};
        vecs[3] = '{8'h11, 4'h8};
        vecs[4] = '{8'h23, 4'h7};

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; td = '1; rnd = '1;
        step(); step();
        chk("reset_valid", out_valid, 0);
        chk("reset_data", {od, oh, ol}, 0);
        rst = 1'b0; in_valid = 1'b0;
        #1 chk("reset_in_ready", in_ready, 1);

        // Single share load, no refresh randomness.
        td = '0; td[0] = 8'h23; rnd = '0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("single_valid", out_valid, 1);
        chk("single_delta", od, 20'h00070);
        chk("single_hi1", oh[0], 4'h2);
        chk("single_lo1", ol[0], 4'h3);

        foreach (vecs[i]) begin
            rand_shares(vecs[i].val);
            rnd = 20'($urandom);
            step();
            chk("table_xor", xor_sh(od), vecs[i].exp_delta);
            chk("table_shares", {od, oh, ol}, m_out(td, rnd));
        end

        // Non-completeness: out_delta_n must ignore in_data_n entirely.
        for (int n = 0; n < 5; n++) begin
            for (int s = 0; s < 5; s++) td[s] = 8'($urandom);
            rnd = 20'($urandom);
            step();
            ref_nib = od[n];
            for (int v = 0; v < 256; v++) begin
                td[n] = 8'(v);
                step();
                chk("noncomplete", od[n], ref_nib);
            end
        end

        // Backpressure: first result held while two more transfers wait.
        in_valid = 1'b0; step();
        rand_shares(8'($urandom)); rnd = 20'($urandom); first_res = m_out(td, rnd);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        rand_shares(8'($urandom)); rnd = 20'($urandom); second_res = m_out(td, rnd);
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_in_ready", in_ready, 0);
            chk("bp_hold", {od, oh, ol}, first_res);
            step();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        step();
        chk("bp_second", {od, oh, ol}, second_res);
        chk("bp_second_valid", out_valid, 1);
        // Drain and refill in the same cycle.
        rand_shares(8'($urandom)); rnd = 20'($urandom); third_res = m_out(td, rnd);
        step();
        chk("refill_valid", out_valid, 1);
        chk("bp_third", {od, oh, ol}, third_res);
        in_valid = 1'b0;
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_hold", {od, oh, ol}, third_res);

        // Reset while stalled discards the held result, even with a transfer offered.
        in_valid = 1'b1; rand_shares(8'h5a); rnd = 20'($urandom);
        step();
        out_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_stall_valid", out_valid, 0);
        chk("rst_stall_data", {od, oh, ol}, 0);
        #1 chk("rst_stall_ready", in_ready, 1);

        // Full-rate random stream against the golden model.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            rand_shares(8'($urandom));
            rnd = 20'($urandom);
            step();
            chk("stream_xor", xor_sh(od), m_delta(td[0] ^ td[1] ^ td[2] ^ td[3] ^ td[4]));
            chk("stream_shares", {od, oh, ol}, m_out(td, rnd));
        end
        in_valid = 1'b0;
        step();

        // Random valid/ready with a scoreboard queue.
        for (int i = 0; i < 3000; i++) begin
            rand_shares(8'($urandom)); rnd = 20'($urandom);
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(2, 0) != 0);
            #1;
            exp_rdy = (exp_q.size() == 0) || out_ready;
            chk("hs_out_valid", out_valid, exp_q.size() != 0);
            chk("hs_in_ready", in_ready, exp_rdy);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("hs_spurious", 1, 0);
                else chk("hs_data", {od, oh, ol}, exp_q.pop_front());
            end
            if (in_valid && exp_rdy) exp_q.push_back(m_out(td, rnd));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
